sd_digit_collector: RTL and testbench
=====================================

Name: sd_digit_collector

Overview:
- Upstream neighbour of the signed-digit-to-binary converter in the BKM FPU datapath.
- Accepts BKM result digits serially, MSB-first, over a valid/ready handshake.
- Packs them into a W-digit, 2W-bit redundant vector, zero-pads early-terminated words, and presents the word on a registered valid/ready output that drives the converter's x input directly.
- Also reports the real digit count and whether the word is canonical (CSD).

Parameters:
- W, 5: number of signed digits per word. Output vector is 2W bits; W >= 2.
- CW (localparam), $clog2(W+1): width of the digit counter and of out_ndig.

Ports:
- clk  input  1  system clock, all state on rising edge.
- arst  input  1  asynchronous active-high reset.
- in_digit  input  2  signed digit {n,p}, value = p - n; 00 and 11 both mean zero.
- in_valid  input  1  in_digit/in_last valid.
- in_last  input  1  final digit of the current word.
- in_ready  output  1  collector can accept a digit.
- out_x  output  2W  packed word; digit i at [2i+1:2i]; digit W-1 is the first received.
- out_valid  output  1  out_x/out_ndig/out_csd_ok valid.
- out_ready  input  1  consumer accepts the word.
- out_ndig  output  CW  number of real (non-pad) digits, 1..W.
- out_csd_ok  output  1  1 = no two adjacent digit positions both nonzero.

Behaviour:
- Clock and reset: single clock, clk. Reset arst is asynchronous and active-high.
- Reset values: state COLLECT, accumulator 0, count 0, csd flag 1, previous-digit-nonzero 0.
- Output values under reset: in_ready=1, out_valid=0, out_x=0, out_ndig=0, out_csd_ok=1.
- States: COLLECT, PAD, HOLD.
- in_ready is 1 only in COLLECT. out_valid is 1 only in HOLD. Both decode from registered state.
- Capture: a digit is accepted on a rising edge with in_valid & in_ready.
  - Digit 11 is normalised to 00 before storage.
  - acc <= {acc[2W-3:0], digit}; count <= count+1.
  - csd <= csd & ~(prev_nz & nz); prev_nz <= nz.
- COLLECT -> HOLD: the accepted digit makes count reach W, whether or not in_last is set. in_last on digit W is legal and has no extra effect.
- COLLECT -> PAD: in_last is accepted with count+1 < W.
- PAD:
  - Shifts in 00 every cycle (acc <= {acc[2W-3:0],2'b00}) and increments a pad counter; count is not incremented.
  - Goes to HOLD when real + pad digits reach W.
  - Pad digits never clear the csd flag.
- Latency: out_valid rises W-k+1 cycles after the edge that accepted the final digit, where k = real digit count. Full word: 1 cycle.
- HOLD:
  - out_x, out_ndig and out_csd_ok are stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: go to COLLECT; clear acc, count, pad counter and prev_nz; set csd to 1.
  - in_ready stays 0 during HOLD, so no digit is accepted in the handoff cycle. Peak throughput is one word per W+1 cycles.
- out_x and out_ndig hold their last values outside HOLD. They are valid only when qualified by out_valid.
- in_valid while in_ready=0 is ignored; the upstream must hold its data.
- arst mid-word or mid-HOLD: the partial or pending word is discarded and all reset values apply immediately.
- No overflow is possible: the counter saturates the word at W by the forced transition to HOLD.

Decomposition:
- Shared package sd_pkg:
  - digit encoding constants SD_ZERO=2'b00, SD_POS=2'b01, SD_NEG=2'b10, SD_ZALT=2'b11;
  - a nonzero-digit function;
  - state encoding constants ST_COLLECT, ST_PAD, ST_HOLD.
- No sub-module: the shift register, counters and CSD flag are small enough to stay inline.

Test Plan (W=5):
- Full word: digits +1,0,-1,0,+1 (01,00,10,00,01), out_ready=1 -> 1 cycle after the 5th accept, out_valid=1, out_x=10'h121, out_ndig=5, out_csd_ok=1. in_ready returns the cycle after the handshake.
- Early last: +1, then -1 with in_last -> 3 PAD cycles, out_valid 4 cycles after the last accept, out_x=10'h180, out_ndig=2, out_csd_ok=0.
- Backpressure: complete a word and hold out_ready=0 for 3 cycles while in_valid=1 -> out_x stable, in_ready=0, no digit consumed. The handshake on cycle 4 restarts the collector and the next word is unaffected.
- Zero alias: digits 11,+1,0,11,+1 -> out_x=10'h041, out_csd_ok=1. Values 11 are stored as 00 and do not break the CSD flag.
- Reset mid-word: accept 3 digits, pulse arst between edges -> outputs return to reset values immediately. A following full word +1,0,0,0,0 gives out_x=10'h100, out_ndig=5.
- Single-digit word: -1 with in_last -> out_valid 5 cycles later, out_x=10'h200, out_ndig=1, out_csd_ok=1.

Source files
------------

// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - signed-digit encodings, collector state codes and digit helpers
package sd_pkg;

  localparam logic [1:0] SD_ZERO = 2'b00;
  localparam logic [1:0] SD_POS  = 2'b01;
  localparam logic [1:0] SD_NEG  = 2'b10;
  localparam logic [1:0] SD_ZALT = 2'b11;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_PAD     = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  function automatic logic sd_nonzero(input logic [1:0] d);
    return (d == SD_POS) || (d == SD_NEG);
  endfunction

  // The 11 alias of zero is folded to 00 so the packed word has one zero code.
  function automatic logic [1:0] sd_norm(input logic [1:0] d);
    return (d == SD_ZALT) ? SD_ZERO : d;
  endfunction

endpackage

// File: rtl/sd_digit_collector.sv
// rtl/sd_digit_collector.sv - packs MSB-first signed digits into a zero-padded
// W-digit redundant word with real digit count and CSD flag
module sd_digit_collector
  import sd_pkg::*;
#(
  parameter  int W  = 5,
  localparam int CW = $clog2(W + 1)
) (
  input  logic            clk,
  input  logic            arst,
  input  logic [1:0]      in_digit,
  input  logic            in_valid,
  input  logic            in_last,
  output logic            in_ready,
  output logic [2*W-1:0]  out_x,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CW-1:0]   out_ndig,
  output logic            out_csd_ok
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2*W-1:0]   r_acc;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    r_pad;
  logic             r_csd;
  logic             r_prev_nz;

  logic             w_accept;
  logic             w_pad_shift;
  logic             w_release;
  logic [1:0]       w_digit;
  logic             w_nz;
  logic [CW-1:0]    w_cnt_inc;
  logic [CW:0]      w_fill;

  assign w_digit   = sd_norm(in_digit);
  assign w_nz      = sd_nonzero(w_digit);
  assign w_cnt_inc = r_cnt + 1'b1;
  // Real digits plus pads after this cycle's pad shift.
  assign w_fill    = {1'b0, r_cnt} + {1'b0, r_pad} + {{CW{1'b0}}, 1'b1};

  assign in_ready   = (r_state == ST_COLLECT);
  assign out_valid  = (r_state == ST_HOLD);
  assign out_x      = r_acc;
  assign out_ndig   = r_cnt;
  assign out_csd_ok = r_csd;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state <= ST_COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_pad_shift = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      ST_COLLECT: begin
        if (in_valid) begin
          w_accept = 1'b1;
          if (w_cnt_inc == CW'(W)) begin
            w_state_nxt = ST_HOLD;
          end else if (in_last) begin
            w_state_nxt = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        w_pad_shift = 1'b1;
        if (w_fill == (CW + 1)'(W)) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          w_release   = 1'b1;
          w_state_nxt = ST_COLLECT;
        end
      end
      default: w_state_nxt = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_pad     <= '0;
      r_csd     <= 1'b1;
      r_prev_nz <= 1'b0;
    end else if (w_release) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_pad     <= '0;
      r_csd     <= 1'b1;
      r_prev_nz <= 1'b0;
    end else if (w_accept) begin
      r_acc     <= {r_acc[2*W-3:0], w_digit};
      r_cnt     <= w_cnt_inc;
      r_csd     <= r_csd & ~(r_prev_nz & w_nz);
      r_prev_nz <= w_nz;
    end else if (w_pad_shift) begin
      r_acc     <= {r_acc[2*W-3:0], SD_ZERO};
      r_pad     <= r_pad + 1'b1;
    end
  end

endmodule

// File: tb/tb_sd_digit_collector.sv
// tb/tb_sd_digit_collector.sv - table-driven scoreboard bench for sd_digit_collector
module tb_sd_digit_collector;

  localparam int W = 5;

  logic       clk;
  logic       arst;
  logic [1:0] in_digit;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [9:0] out_x;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_ndig;
  logic       out_csd_ok;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [9:0] digs;
    logic [2:0] n;
    logic [9:0] x;
    logic [2:0] nd;
    logic       csd;
  } vec_t;

  typedef struct packed {
    logic [9:0] x;
    logic [2:0] nd;
    logic       csd;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[7];

  sd_digit_collector #(.W(W)) dut (
    .clk        (clk),
    .arst       (arst),
    .in_digit   (in_digit),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .out_x      (out_x),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ndig   (out_ndig),
    .out_csd_ok (out_csd_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive_digit(input logic [1:0] d, input logic last);
    int g;
    @(negedge clk);
    in_valid = 1'b1;
    in_digit = d;
    in_last  = last;
    g = 0;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) chk("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_word(input vec_t v);
    exp_t       e;
    int         lat;
    logic [9:0] dg;
    e  = {v.x, v.nd, v.csd};
    exp_q.push_back(e);
    dg = v.digs;
    for (int i = 0; i < int'(v.n); i++) begin
      drive_digit(dg[9-2*i -: 2], (i == int'(v.n) - 1));
    end
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, W - int'(v.n) + 1);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!arst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("out_x", out_x, e.x);
        chk("out_ndig", out_ndig, e.nd);
        chk("out_csd_ok", out_csd_ok, e.csd);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    tbl[0] = {10'b01_00_10_00_01, 3'd5, 10'h121, 3'd5, 1'b1};
    tbl[1] = {10'b01_10_00_00_00, 3'd2, 10'h180, 3'd2, 1'b0};
    tbl[2] = {10'b11_01_00_11_01, 3'd5, 10'h041, 3'd5, 1'b1};
    tbl[3] = {10'b10_00_00_00_00, 3'd1, 10'h200, 3'd1, 1'b1};
    tbl[4] = {10'b01_00_01_00_00, 3'd3, 10'h110, 3'd3, 1'b1};
    tbl[5] = {10'b10_10_10_10_10, 3'd5, 10'h2AA, 3'd5, 1'b0};
    tbl[6] = {10'b01_00_00_00_00, 3'd5, 10'h100, 3'd5, 1'b1};

    arst      = 1'b1;
    in_valid  = 1'b0;
    in_digit  = 2'b00;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_x", out_x, 0);
    chk("rst_out_ndig", out_ndig, 0);
    chk("rst_out_csd_ok", out_csd_ok, 1);
    #10;
    arst = 1'b0;

    send_word(tbl[0]);
    @(posedge clk);
    #1;
    chk("in_ready_after_hs", in_ready, 1);
    chk("out_valid_after_hs", out_valid, 0);

    for (int i = 1; i < 5; i++) send_word(tbl[i]);

    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send_word(tbl[5]);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_digit = 2'b01;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_x", out_x, 10'h2AA);
      chk("bp_out_ndig", out_ndig, 5);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    drive_digit(2'b01, 1'b0);
    drive_digit(2'b01, 1'b0);
    drive_digit(2'b01, 1'b0);
    chk("partial_out_x", out_x, 10'h015);
    @(negedge clk);
    #2;
    arst = 1'b1;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_x", out_x, 0);
    chk("mid_rst_out_ndig", out_ndig, 0);
    chk("mid_rst_out_csd_ok", out_csd_ok, 1);
    #1;
    arst = 1'b0;

    send_word(tbl[6]);
    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    chk("idle_out_valid", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
